// File: rtl/axi_ic_pkg.sv
// Shared types and helpers for the AXI interconnect read path.
package axi_ic_pkg;
  localparam int NUM_SLAVES = 4;

  typedef logic [1:0] slave_id_t;

  // R-channel transfer: only counts when a burst is actually routed.
  function automatic logic r_handshake(input logic route_ok, input logic vld, input logic rdy);
    return route_ok & vld & rdy;
  endfunction
endpackage

// File: rtl/rd_route_fifo.sv
// In-order queue of slave ids for outstanding read bursts.
module rd_route_fifo
  import axi_ic_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [1:0]       din,
  input  logic             pop,
  output logic [1:0]       head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  slave_id_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // full is registered state, so a same-cycle pop never frees a slot for a push
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/axi_rd_route_ctrl.sv
// Routes R responses from 4 slaves back to the master in AR acceptance order.
module axi_rd_route_ctrl
  import axi_ic_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             ar_push_valid,
  input  logic [1:0]       ar_push_slave,
  output logic             ar_full,
  input  logic             m_rvalid,
  input  logic             m_rlast,
  input  logic             m_rready,
  output logic             m_rvalid_q,
  output logic [1:0]       sel,
  output logic             route_valid,
  output logic [3:0]       s_rready,
  output logic [CNT_W-1:0] outstanding,
  output logic [7:0]       beat_cnt,
  output logic             overflow_err
);
  logic       empty, r_hs, pop;
  logic [1:0] head;

  rd_route_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (ar_push_valid),
    .din   (ar_push_slave),
    .pop   (pop),
    .head  (head),
    .full  (ar_full),
    .empty (empty),
    .count (outstanding)
  );

  assign route_valid = ~empty;
  assign r_hs        = r_handshake(route_valid, m_rvalid, m_rready);
  assign pop         = r_hs & m_rlast;
  assign m_rvalid_q  = m_rvalid & route_valid;
  // select comes only from registered FIFO state; idle parks on slave 0
  assign sel         = route_valid ? head : 2'b00;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_rready
    assign s_rready[i] = route_valid & m_rready & (sel == slave_id_t'(i));
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      beat_cnt     <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (pop)       beat_cnt <= '0;
      else if (r_hs) beat_cnt <= beat_cnt + 1'b1;
      if (ar_push_valid & ar_full) overflow_err <= 1'b1;
    end
  end
endmodule

// File: doc/axi_rd_route_ctrl.md
Name: axi_rd_route_ctrl

Overview:
- Read-response routing controller for the AXI interconnect's 4-slave to 1-master read path.
- Records the target slave of every accepted AR transfer, in order, in an outstanding-read FIFO.
- Drives the select input of the downstream 4:1 read-data mux (RDATA/RVALID/RLAST/RRESP) from the FIFO head.
- Demultiplexes master RREADY to the selected slave and retires an entry on each RLAST handshake.

Parameters:
- DEPTH, 4: maximum outstanding read bursts; power of 2, >= 2.
- CNT_W, $clog2(DEPTH+1): width of the outstanding-count output.

Ports:
- ACLK  in  1  clock; all state updates on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- ar_push_valid  in  1  AR handshake to a slave completed this cycle.
- ar_push_slave  in  2  slave index (0-3) of that AR, from the address decoder.
- ar_full  out  1  FIFO full; upstream AR arbiter must hold ARREADY low.
- m_rvalid  in  1  RVALID at the mux output.
- m_rlast  in  1  RLAST at the mux output.
- m_rready  in  1  RREADY from the master.
- m_rvalid_q  out  1  qualified RVALID to the master = m_rvalid & route_valid.
- sel  out  2  select to the 4:1 read mux.
- route_valid  out  1  FIFO non-empty; a routed burst is active.
- s_rready  out  4  per-slave RREADY.
- outstanding  out  CNT_W  number of queued bursts.
- beat_cnt  out  8  beats accepted in the current burst; wraps modulo 256.
- overflow_err  out  1  sticky; set when a push arrives while full.

Behaviour:
- Reset: wr_ptr, rd_ptr and count are 0. sel=2'b00, route_valid=0, ar_full=0, s_rready=0, m_rvalid_q=0, outstanding=0, beat_cnt=0, overflow_err=0.
- Reset mid-burst discards all queued entries. Reset has priority over push and pop in the same cycle.
- Push: when ar_push_valid & ~ar_full, write ar_push_slave at wr_ptr, increment wr_ptr modulo DEPTH, and increment count.
- Pop: when route_valid & m_rvalid & m_rready & m_rlast, increment rd_ptr modulo DEPTH, decrement count, and clear beat_cnt.
- Beat count: on any other R handshake (route_valid & m_rvalid & m_rready, not last), beat_cnt increments.
- Simultaneous push and pop while not full: both occur and count is unchanged.
- Push while full: ignored even if a pop happens in the same cycle, and overflow_err is set to 1 until reset. ar_full is derived from the registered count, so there is no combinational path from pop.
- Pop while empty: impossible, since route_valid=0 blocks it.
- route_valid = (count != 0), registered state.
- sel = FIFO[rd_ptr] when route_valid, else 2'b00. It is derived from registered state only, giving no combinational path from the R inputs to the mux select.
- Latency: a push into an empty FIFO raises route_valid and updates sel on the next cycle. A pop takes effect at the clock edge, and the next head is selected in the following cycle with no bubble.
- s_rready[i] = route_valid & m_rready & (sel == i). This is combinational from m_rready; all other bits are 0.
- m_rvalid_q blocks stray slave RVALIDs while no burst is routed.
- A slave asserting RVALID out of order is not selected and stalls until its entry reaches the head.
- ar_full = (count == DEPTH). outstanding = count.

Decomposition:
- Package axi_ic_pkg holds:
  - NUM_SLAVES = 4;
  - typedef logic [1:0] slave_id_t (also used by the mux select);
  - the R-handshake helper function.
- One natural sub-module: rd_route_fifo, a generic synchronous FIFO of slave_id_t with push, pop, full, empty and count.
- The top level adds handshake qualification, RREADY demux, beat counter and error flag.

Test Plan:
- Reset → single burst: push slave 2 → next cycle sel=2, route_valid=1. Drive 4 beats with RLAST on beat 4, m_rready=1 → s_rready=4'b0100 throughout, beat_cnt 0→1→2→3 then 0, route_valid=0 after the last beat.
- Ordering: push slaves 1,3,0 back-to-back; complete 2-beat bursts → sel sequence 1,3,0 with no idle cycle between bursts; outstanding 3→2→1→0.
- Full and overflow (DEPTH=4): push 4 → ar_full=1, outstanding=4. Push a 5th in the same cycle as an RLAST pop → 5th dropped, overflow_err=1 sticky, outstanding=3 next cycle.
- Backpressure: m_rvalid=1 and m_rlast=1 with m_rready=0 for 3 cycles → no pop, s_rready=0, sel stable; pop occurs on the first cycle with m_rready=1.
- Stray response: FIFO empty, m_rvalid=1 → m_rvalid_q=0, s_rready=0.
- Reset mid-burst: 2 entries queued, ARESET=1 for 1 cycle mid-beat → all outputs at reset values next cycle; a subsequent push of slave 3 routes correctly.
